// File: rtl/ann_pkg.sv
// Shared constants, FSM state type and output saturation helper for the ANN neuron engines.
package ann_pkg;

  localparam int DATA_W    = 16;
  localparam int FRAC_BITS = 8;
  localparam int ACC_W     = 40;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2,
    OUT    = 2'd3
  } state_t;

  // Clamp an already-rescaled value into the signed DATA_W range, optionally zeroing negatives.
  function automatic logic [DATA_W-1:0] sat_relu(input logic signed [ACC_W-1:0] v,
                                                 input logic relu);
    logic signed [ACC_W-1:0] max_v;
    logic signed [ACC_W-1:0] min_v;
    logic [DATA_W-1:0] r;
    max_v = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    min_v = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    if (relu && (v < 0))  r = '0;
    else if (v > max_v)   r = {1'b0, {(DATA_W-1){1'b1}}};
    else if (v < min_v)   r = {1'b1, {(DATA_W-1){1'b0}}};
    else                  r = v[DATA_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/neuron_mac_datapath.sv
// Multiplier, accumulator and read-valid tracking for one neuron dot product.
module neuron_mac_datapath #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     rd_issue,
  input  logic signed [DATA_W-1:0] w_do,
  input  logic signed [DATA_W-1:0] x_do,
  output logic                     rd_valid,
  output logic signed [ACC_W-1:0]  acc
);
  import ann_pkg::*;

  logic signed [2*DATA_W-1:0] prod;

  assign prod = (2*DATA_W)'(w_do) * (2*DATA_W)'(x_do);

  // rd_valid is high in every cycle whose negedge read returns data by the next posedge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      acc      <= '0;
    end else begin
      rd_valid <= rd_issue;
      if (clr)           acc <= '0;
      else if (rd_valid) acc <= acc + ACC_W'(prod);
    end
  end

endmodule

// File: rtl/neuron_mac_unit.sv
// Single-neuron MAC engine: sweeps the shared BRAM address, accumulates, biases, rescales, saturates.
// Output handshake: a result transfers on a posedge where OUT_VALID && OUT_READY; OUT_DATA/OUT_VALID hold until then.
module neuron_mac_unit #(
  parameter int N_INPUTS  = 28,
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 16,
  parameter int FRAC_BITS = 8,
  parameter int ACC_W     = 40,
  parameter int RELU      = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [DATA_W-1:0] BIAS,
  output logic [ADDR_W-1:0] ADDR,
  output logic              EN,
  input  logic [DATA_W-1:0] W_DO,
  input  logic [DATA_W-1:0] X_DO,
  output logic              BUSY,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [1:0]        state_dbg
);
  import ann_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_INPUTS - 1);

  state_t                    state;
  logic                      rd_issue;
  logic                      clr;
  logic                      rd_valid;
  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   bias_ext;
  logic signed [ACC_W-1:0]   sum;
  logic signed [ACC_W-1:0]   scaled;

  always_comb begin
    clr      = (state == IDLE) && START;
    rd_issue = clr || ((state == RUN) && (ADDR != LAST_ADDR));
    bias_ext = {{(ACC_W-DATA_W){BIAS[DATA_W-1]}}, BIAS};
    sum      = acc + (bias_ext <<< FRAC_BITS);
    scaled   = sum >>> FRAC_BITS;
  end

  assign BUSY      = (state != IDLE);
  assign state_dbg = state;

  neuron_mac_datapath #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_datapath (
    .clk      (CLK),
    .rst      (RST),
    .clr      (clr),
    .rd_issue (rd_issue),
    .w_do     (W_DO),
    .x_do     (X_DO),
    .rd_valid (rd_valid),
    .acc      (acc)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      ADDR      <= '0;
      EN        <= 1'b0;
      OUT_DATA  <= '0;
      OUT_VALID <= 1'b0;
    end else begin
      EN <= rd_issue;
      case (state)
        IDLE: begin
          ADDR <= '0;
          if (START) state <= RUN;
        end
        RUN: begin
          // The last address was presented last cycle; its data lands on this edge.
          if (ADDR == LAST_ADDR) begin
            ADDR  <= '0;
            state <= FINISH;
          end else begin
            ADDR <= ADDR + 1'b1;
          end
        end
        FINISH: begin
          OUT_DATA  <= sat_relu(scaled, RELU != 0);
          OUT_VALID <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (OUT_READY) begin
            OUT_VALID <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_mac_unit.sv
// Scoreboard bench for neuron_mac_unit: a ReLU and a non-ReLU instance see identical stimulus.
module tb_neuron_mac_unit;
  localparam int N = 28;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] bias;
  logic        out_ready;

  logic [4:0]  addr_a, addr_b;
  logic        en_a, en_b;
  logic [15:0] w_a, x_a, w_b, x_b;
  logic        busy_a, busy_b;
  logic [15:0] od_a, od_b;
  logic        ov_a, ov_b;
  logic [1:0]  st_a, st_b;

  logic signed [15:0] w_mem [N];
  logic signed [15:0] x_mem [N];

  logic [15:0] exp_q[$];
  logic [15:0] exp_nr_q[$];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int addr_cnt [N];
  int bad_addr = 0;
  int en_cnt   = 0;

  neuron_mac_unit #(.RELU(1)) dut (
    .CLK(clk), .RST(rst), .START(start), .BIAS(bias), .ADDR(addr_a), .EN(en_a),
    .W_DO(w_a), .X_DO(x_a), .BUSY(busy_a), .OUT_DATA(od_a), .OUT_VALID(ov_a),
    .OUT_READY(out_ready), .state_dbg(st_a)
  );

  neuron_mac_unit #(.RELU(0)) dut_nr (
    .CLK(clk), .RST(rst), .START(start), .BIAS(bias), .ADDR(addr_b), .EN(en_b),
    .W_DO(w_b), .X_DO(x_b), .BUSY(busy_b), .OUT_DATA(od_b), .OUT_VALID(ov_b),
    .OUT_READY(out_ready), .state_dbg(st_b)
  );

  // ---------------- clock / reset / memories ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (en_a) begin
      w_a <= w_mem[addr_a];
      x_a <= x_mem[addr_a];
      en_cnt <= en_cnt + 1;
      if (int'(addr_a) < N) addr_cnt[addr_a] <= addr_cnt[addr_a] + 1;
      else                  bad_addr <= bad_addr + 1;
    end
    if (en_b) begin
      w_b <= w_mem[addr_b];
      x_b <= x_mem[addr_b];
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ref_model(input bit relu, input logic signed [15:0] b);
    longint s;
    longint r;
    s = 0;
    for (int i = 0; i < N; i++) s += longint'(w_mem[i]) * longint'(x_mem[i]);
    s += longint'(b) * 256;
    r = s >>> 8;
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
    if (relu && r < 0) r = 0;
    return r[15:0];
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    #1;
    if (!rst && out_ready && ov_a) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL out_relu: unexpected result %0h with empty queue", od_a);
      end else check("out_relu", od_a, exp_q.pop_front());
    end
    if (!rst && out_ready && ov_b) begin
      if (exp_nr_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL out_signed: unexpected result %0h with empty queue", od_b);
      end else check("out_signed", od_b, exp_nr_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic load_const(input logic [15:0] w, input logic [15:0] x);
    for (int i = 0; i < N; i++) begin
      w_mem[i] = w;
      x_mem[i] = x;
    end
  endtask

  task automatic load_random();
    for (int i = 0; i < N; i++) begin
      w_mem[i] = 16'($urandom_range(0, 65535));
      x_mem[i] = 16'($urandom_range(0, 65535));
    end
  endtask

  task automatic do_op(input logic [15:0] b, input logic [15:0] e_relu,
                       input logic [15:0] e_signed, input int hold, input bit chk_addr);
    int t0;
    int n;
    int ok;
    logic [15:0] held;
    for (int i = 0; i < N; i++) addr_cnt[i] = 0;
    bad_addr = 0;
    en_cnt   = 0;
    out_ready = (hold == 0);
    @(negedge clk);
    start = 1'b1;
    bias  = b;
    exp_q.push_back(e_relu);
    exp_nr_q.push_back(e_signed);
    @(negedge clk);
    start = 1'b0;
    t0 = cyc;
    check("busy_running", busy_a, 1);
    n = 0;
    while (!ov_a && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!ov_a) begin
      tests++; fails++;
      $display("FAIL valid_timeout: no OUT_VALID within 40 cycles, expected within 29");
      exp_q.delete();
      exp_nr_q.delete();
      out_ready = 1'b1;
      return;
    end
    check("latency", cyc - t0, 29);
    if (chk_addr) begin
      ok = 0;
      for (int i = 0; i < N; i++) if (addr_cnt[i] == 1) ok++;
      check("addr_sweep_once", ok, N);
      check("addr_out_of_range", bad_addr, 0);
      check("en_cycles", en_cnt, N);
    end
    if (hold > 0) begin
      held = od_a;
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        start = k[0];
        check("hold_valid", ov_a, 1);
        check("hold_data", od_a, held);
      end
      @(negedge clk);
      out_ready = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("valid_fall", ov_a, 0);
      check("busy_after_handshake", busy_a, 0);
      @(negedge clk);
      check("start_ignored_in_out", busy_a, 0);
    end else begin
      @(negedge clk);
      check("valid_fall", ov_a, 0);
    end
  endtask

  task automatic mid_reset();
    int n;
    load_const(16'h0100, 16'h0100);
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (addr_a != 5'd12 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("reach_addr12", addr_a, 12);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_en", en_a, 0);
    check("rst_addr", addr_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_valid", ov_a, 0);
  endtask

  task automatic continuous_start();
    int rises[$];
    logic prev;
    load_const(16'h0100, 16'h0100);
    out_ready = 1'b1;
    prev = 1'b0;
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(16'h1C00);
      exp_nr_q.push_back(16'h1C00);
    end
    repeat (93) begin
      @(negedge clk);
      if (ov_a && !prev) rises.push_back(cyc);
      prev = ov_a;
    end
    start = 1'b0;
    check("cont_result_count", rises.size(), 3);
    if (rises.size() == 3) begin
      check("cont_period_1", rises[1] - rises[0], 31);
      check("cont_period_2", rises[2] - rises[1], 31);
    end
    repeat (3) @(negedge clk);
    check("cont_idle_after", busy_a, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [15:0] rb;
    rst = 1'b1;
    start = 1'b0;
    bias = '0;
    out_ready = 1'b1;
    load_const(16'h0000, 16'h0000);
    repeat (3) @(negedge clk);
    check("reset_addr", addr_a, 0);
    check("reset_en", en_a, 0);
    check("reset_busy", busy_a, 0);
    check("reset_out_data", od_a, 0);
    check("reset_out_valid", ov_a, 0);
    rst = 1'b0;
    @(negedge clk);

    load_const(16'h0100, 16'h0100);
    do_op(16'h0000, 16'h1C00, 16'h1C00, 0, 1'b1);

    load_const(16'hFF00, 16'h0100);
    do_op(16'h0000, 16'h0000, 16'hE400, 0, 1'b0);

    load_const(16'h7FFF, 16'h7FFF);
    do_op(16'h7FFF, 16'h7FFF, 16'h7FFF, 0, 1'b0);

    load_const(16'h8000, 16'h7FFF);
    do_op(16'h0000, 16'h0000, 16'h8000, 0, 1'b0);

    load_const(16'h0000, 16'h1234);
    do_op(16'h0280, 16'h0280, 16'h0280, 10, 1'b0);

    mid_reset();
    load_const(16'h0100, 16'h0100);
    do_op(16'h0000, 16'h1C00, 16'h1C00, 0, 1'b1);

    continuous_start();

    for (int t = 0; t < 6; t++) begin
      load_random();
      rb = 16'($urandom_range(0, 65535));
      do_op(rb, ref_model(1'b1, rb), ref_model(1'b0, rb), (t == 3) ? 2 : 0, 1'b1);
    end

    repeat (3) @(negedge clk);
    check("queue_drained_relu", exp_q.size(), 0);
    check("queue_drained_signed", exp_nr_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
